batch_consumer: RTL and testbench

BATCH_CONSUMER -- requirements
Module: batch_consumer

---
 rtl/pixel_defs.sv | 20 ++
 rtl/batch_pingpong.sv | 59 +++++
 rtl/batch_consumer.sv | 147 ++++++++++++++
 tb/tb_batch_consumer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_defs.sv
// Shared pixel/batch geometry and producer FSM encodings.
// Used by batch_consumer and the pixel processor.
package pixel_defs;

    localparam int SCREEN_WIDTH      = 640;
    localparam int SCREEN_HEIGHT     = 480;
    localparam int NUM_PIXELS        = 8;
    localparam int PIXEL_WIDTH       = 12;
    localparam int BATCHES_PER_FRAME =
        SCREEN_WIDTH * SCREEN_HEIGHT / NUM_PIXELS;
    localparam int BATCH_CNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_RESULT = 2'd1,
        ST_ACK         = 2'd2,
        ST_DONE        = 2'd3
    } prod_state_t;

endpackage

// File: rtl/batch_pingpong.sv
// Two-slot batch store with write/read pointers and occupancy.
// Caller guarantees no write when full and no free when empty.
module batch_pingpong #(
    parameter int NUM_PIXELS  = pixel_defs::NUM_PIXELS,
    parameter int PIXEL_WIDTH = pixel_defs::PIXEL_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              wr_en,
    input  logic [NUM_PIXELS*PIXEL_WIDTH-1:0] wr_data,
    input  logic                              rd_free,
    output logic [NUM_PIXELS*PIXEL_WIDTH-1:0] rd_data,
    output logic                              full,
    output logic                              empty
);
    import pixel_defs::*;

    localparam int BATCH_W = NUM_PIXELS * PIXEL_WIDTH;

    logic [BATCH_W-1:0] slot_q [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         occ_q;

    // Pointers and occupancy; clear drops any buffered batches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else if (clear) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (wr_en)
                wr_ptr_q <= ~wr_ptr_q;
            if (rd_free)
                rd_ptr_q <= ~rd_ptr_q;
            case ({wr_en, rd_free})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Slot data needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (wr_en)
            slot_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = slot_q[rd_ptr_q];
    assign full    = (occ_q == 2'd2);
    assign empty   = (occ_q == 2'd0);

endmodule

// File: rtl/batch_consumer.sv
// Buffers pixel batches from the processor and streams pixels
// to the display, one per request, with 1-cycle latency.
module batch_consumer #(
    parameter int NUM_PIXELS        = pixel_defs::NUM_PIXELS,
    parameter int PIXEL_WIDTH       = pixel_defs::PIXEL_WIDTH,
    parameter int BATCHES_PER_FRAME = pixel_defs::BATCHES_PER_FRAME
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PIXELS*PIXEL_WIDTH-1:0] result,
    input  logic                              result_ready,
    output logic                              new_frame,
    output logic                              start_next_batch,
    input  logic                              frame_start,
    input  logic                              pixel_request,
    output logic [PIXEL_WIDTH-1:0]            pixel_out,
    output logic                              pixel_valid,
    output logic                              underrun
);
    import pixel_defs::*;

    localparam int BATCH_W = NUM_PIXELS * PIXEL_WIDTH;
    localparam int IDX_W   =
        (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST =
        IDX_W'(NUM_PIXELS - 1);
    localparam logic [BATCH_CNT_WIDTH-1:0] CNT_LAST =
        BATCH_CNT_WIDTH'(BATCHES_PER_FRAME);

    prod_state_t                state_q;
    prod_state_t                state_d;
    logic [BATCH_CNT_WIDTH-1:0] batch_cnt_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       capture;
    logic                       slot_free;
    logic                       buf_full;
    logic                       buf_empty;
    logic [BATCH_W-1:0]         rd_batch;
    logic [PIXEL_WIDTH-1:0]     pixels [NUM_PIXELS];

    assign slot_free = !frame_start && pixel_request &&
                       !buf_empty && (idx_q == IDX_LAST);

    batch_pingpong #(
        .NUM_PIXELS  (NUM_PIXELS),
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_pingpong (
        .clk     (clk),
        .reset   (reset),
        .clear   (frame_start),
        .wr_en   (capture),
        .wr_data (result),
        .rd_free (slot_free),
        .rd_data (rd_batch),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    // Producer FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state; frame_start overrides every state.
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = ST_WAIT_RESULT;
        end else begin
            unique case (state_q)
                ST_IDLE:        state_d = ST_IDLE;
                ST_WAIT_RESULT:
                    if (result_ready && !buf_full)
                        state_d = ST_ACK;
                ST_ACK:
                    state_d = (batch_cnt_q == CNT_LAST) ?
                              ST_DONE : ST_WAIT_RESULT;
                ST_DONE:        state_d = ST_DONE;
                default:        state_d = ST_IDLE;
            endcase
        end
    end

    // Capture only in WAIT_RESULT, using pre-edge occupancy.
    always_comb begin
        capture = 1'b0;
        unique case (state_q)
            ST_WAIT_RESULT:
                capture = !frame_start && result_ready && !buf_full;
            default:
                capture = 1'b0;
        endcase
    end

    // Registered handshake pulses and the per-frame batch count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            new_frame        <= 1'b0;
            start_next_batch <= 1'b0;
            batch_cnt_q      <= '0;
        end else begin
            new_frame        <= frame_start;
            start_next_batch <= capture;
            if (frame_start)
                batch_cnt_q <= '0;
            else if (capture)
                batch_cnt_q <= batch_cnt_q + 1'b1;
        end
    end

    // Split the read slot into individual pixels.
    always_comb begin
        for (int i = 0; i < NUM_PIXELS; i++)
            pixels[i] = rd_batch[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    end

    // Pixel output mux, index advance and sticky underrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
            idx_q       <= '0;
            underrun    <= 1'b0;
        end else if (frame_start) begin
            pixel_valid <= 1'b0;
            idx_q       <= '0;
            underrun    <= 1'b0;
        end else if (pixel_request) begin
            if (!buf_empty) begin
                pixel_out   <= pixels[idx_q];
                pixel_valid <= 1'b1;
                idx_q       <= (idx_q == IDX_LAST) ?
                               '0 : idx_q + IDX_W'(1);
            end else begin
                pixel_out   <= '0;
                pixel_valid <= 1'b0;
                underrun    <= 1'b1;
            end
        end else begin
            pixel_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_batch_consumer.sv
// Directed bench for batch_consumer with hand-computed expectations.
// The frame length is shortened so a whole frame fits in a short run.
module tb_batch_consumer;

    localparam int NP  = 8;
    localparam int PW  = 12;
    localparam int BPF = 5;
    localparam int BW  = NP * PW;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] result;
    logic          result_ready;
    logic          new_frame;
    logic          start_next_batch;
    logic          frame_start;
    logic          pixel_request;
    logic [PW-1:0] pixel_out;
    logic          pixel_valid;
    logic          underrun;

    int n_cmp = 0;
    int n_err = 0;
    int snb_cnt;

    logic [11:0] exp_a [8];

    batch_consumer #(
        .NUM_PIXELS        (NP),
        .PIXEL_WIDTH       (PW),
        .BATCHES_PER_FRAME (BPF)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .result           (result),
        .result_ready     (result_ready),
        .new_frame        (new_frame),
        .start_next_batch (start_next_batch),
        .frame_start      (frame_start),
        .pixel_request    (pixel_request),
        .pixel_out        (pixel_out),
        .pixel_valid      (pixel_valid),
        .underrun         (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Batch whose pixel i is base+i.
    function automatic logic [BW-1:0] mk(input logic [11:0] base);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < NP; i++)
            b[i*PW +: PW] = base + 12'(i);
        return b;
    endfunction

    task automatic pulse_frame(input string tag);
        frame_start = 1'b1;
        tick();
        check(tag, 32'(new_frame), 32'd1);
        frame_start = 1'b0;
    endtask

    task automatic read_batch(input string tag,
                              input logic [11:0] base);
        pixel_request = 1'b1;
        for (int i = 0; i < NP; i++) begin
            tick();
            check({tag, "_v"}, 32'(pixel_valid), 32'd1);
            check({tag, "_px"}, 32'(pixel_out),
                  32'(base + 12'(i)));
        end
        pixel_request = 1'b0;
    endtask

    initial begin
        exp_a = '{12'h321, 12'h654, 12'h987, 12'h0BA,
                  12'h444, 12'h333, 12'h222, 12'h111};
        reset         = 1'b1;
        result        = '0;
        result_ready  = 1'b0;
        frame_start   = 1'b0;
        pixel_request = 1'b0;
        repeat (2) tick();
        check("rst_nf", 32'(new_frame), 32'd0);
        check("rst_snb", 32'(start_next_batch), 32'd0);
        check("rst_pv", 32'(pixel_valid), 32'd0);
        check("rst_po", 32'(pixel_out), 32'd0);
        check("rst_ur", 32'(underrun), 32'd0);
        reset = 1'b0;
        tick();

        // IDLE ignores result_ready
        result       = mk(12'h0AA);
        result_ready = 1'b1;
        snb_cnt      = 0;
        repeat (3) begin
            tick();
            snb_cnt += int'(start_next_batch);
        end
        check("idle_snb", 32'(snb_cnt), 32'd0);
        result_ready = 1'b0;

        pulse_frame("nf_pulse");
        tick();
        check("nf_once", 32'(new_frame), 32'd0);
        snb_cnt = 0;
        repeat (3) begin
            tick();
            snb_cnt += int'(start_next_batch);
        end
        check("no_rr_snb", 32'(snb_cnt), 32'd0);

        // one batch; producer drops ready after the ACK cycle
        result       = 96'h111_222_333_444_0BA_987_654_321;
        result_ready = 1'b1;
        snb_cnt      = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            snb_cnt += int'(start_next_batch);
            if (i == 1)
                result_ready = 1'b0;
        end
        check("a_pulses", 32'(snb_cnt), 32'd1);
        pixel_request = 1'b1;
        for (int i = 0; i < NP; i++) begin
            tick();
            check("a_v", 32'(pixel_valid), 32'd1);
            check("a_px", 32'(pixel_out), 32'(exp_a[i]));
        end
        pixel_request = 1'b0;
        tick();
        check("a_idle_v", 32'(pixel_valid), 32'd0);
        check("a_hold", 32'(pixel_out), 32'h111);

        // underrun on empty buffer
        pixel_request = 1'b1;
        tick();
        check("ur_v", 32'(pixel_valid), 32'd0);
        check("ur_po", 32'(pixel_out), 32'd0);
        check("ur_set", 32'(underrun), 32'd1);
        pixel_request = 1'b0;
        repeat (3) tick();
        check("ur_sticky", 32'(underrun), 32'd1);

        // fill both slots, then refill after a free
        result       = mk(12'h100);
        result_ready = 1'b1;
        snb_cnt      = 0;
        tick();
        snb_cnt += int'(start_next_batch);
        result = mk(12'h200);
        tick();
        snb_cnt += int'(start_next_batch);
        tick();
        snb_cnt += int'(start_next_batch);
        result = mk(12'h300);
        repeat (6) begin
            tick();
            snb_cnt += int'(start_next_batch);
        end
        check("c_two", 32'(snb_cnt), 32'd2);
        pixel_request = 1'b1;
        for (int i = 0; i < NP; i++) begin
            tick();
            check("c_b1_px", 32'(pixel_out), 32'(12'h100 + 12'(i)));
            check("c_nocap", 32'(start_next_batch), 32'd0);
        end
        pixel_request = 1'b0;
        tick();
        check("c_third", 32'(start_next_batch), 32'd1);
        result_ready = 1'b0;
        read_batch("c_b2", 12'h200);
        read_batch("c_b3", 12'h300);
        pixel_request = 1'b1;
        tick();
        check("c_empty", 32'(pixel_valid), 32'd0);
        pixel_request = 1'b0;

        // full frame of BPF batches, then DONE
        pulse_frame("d_nf");
        check("d_ur_clr", 32'(underrun), 32'd0);
        for (int k = 0; k < BPF; k++) begin
            result       = mk(12'h400 + 12'(k * 16));
            result_ready = 1'b1;
            tick();
            check("d_snb", 32'(start_next_batch), 32'd1);
            tick();
            result_ready = 1'b0;
            read_batch("d_rd", 12'h400 + 12'(k * 16));
        end
        result       = mk(12'h4F0);
        result_ready = 1'b1;
        snb_cnt      = 0;
        repeat (6) begin
            tick();
            snb_cnt += int'(start_next_batch);
        end
        check("d_done", 32'(snb_cnt), 32'd0);
        pixel_request = 1'b1;
        tick();
        check("d_nodata", 32'(pixel_valid), 32'd0);
        pixel_request = 1'b0;
        result_ready  = 1'b0;
        pulse_frame("d_nf2");
        result       = mk(12'h500);
        result_ready = 1'b1;
        tick();
        check("d_resume", 32'(start_next_batch), 32'd1);
        tick();
        result_ready  = 1'b0;
        pixel_request = 1'b1;
        tick();
        check("d_px", 32'(pixel_out), 32'h500);
        pixel_request = 1'b0;

        // reset while in ACK with both slots full
        pulse_frame("e_nf");
        result       = mk(12'h600);
        result_ready = 1'b1;
        tick();
        result = mk(12'h700);
        tick();
        tick();
        check("e_pre", 32'(start_next_batch), 32'd1);
        reset = 1'b1;
        #1;
        check("e_snb", 32'(start_next_batch), 32'd0);
        check("e_nf0", 32'(new_frame), 32'd0);
        check("e_pv", 32'(pixel_valid), 32'd0);
        check("e_po", 32'(pixel_out), 32'd0);
        check("e_ur", 32'(underrun), 32'd0);
        result_ready = 1'b0;
        tick();
        tick();
        reset        = 1'b0;
        result       = mk(12'h800);
        result_ready = 1'b1;
        snb_cnt      = 0;
        repeat (4) begin
            tick();
            snb_cnt += int'(start_next_batch) + int'(new_frame);
        end
        check("e_quiet", 32'(snb_cnt), 32'd0);
        frame_start = 1'b1;
        tick();
        check("e_nf", 32'(new_frame), 32'd1);
        check("e_fs_prio", 32'(start_next_batch), 32'd0);
        frame_start = 1'b0;
        tick();
        check("e_cap", 32'(start_next_batch), 32'd1);
        tick();
        result_ready  = 1'b0;
        pixel_request = 1'b1;
        tick();
        check("e_first_v", 32'(pixel_valid), 32'd1);
        check("e_first", 32'(pixel_out), 32'h800);
        pixel_request = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
